// File: rtl/md_unit_pkg.sv
// Shared md-unit constants: op codes and register-write-source codes.
// Also holds small decode helpers used by the md controller.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // write-back source codes for mfhi/mflo in the E result mux
    localparam logic [2:0] RS_HI = 3'd4;
    localparam logic [2:0] RS_LO = 3'd5;

    function automatic logic is_launch(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MADDU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_arith.sv
// Combinational md arithmetic: result {hi,lo} for a launch op.
// Ports: op, a, b, hi, lo in; res_hi, res_lo out.
module md_unit_arith
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] sprod;
    logic [2*WIDTH-1:0] uprod;
    logic [WIDTH-1:0]   sq;
    logic [WIDTH-1:0]   sr;
    logic               b_zero;
    logic               s_ovf;

    assign acc = {hi, lo};
    // low 2W bits of the product of sign-extended operands = signed product
    assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign b_zero = (b == '0);
    assign s_ovf = (a == SMIN) && (b == '1);
    assign sq = $signed(a) / $signed(b);
    assign sr = $signed(a) % $signed(b);

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MD_MULT:  {res_hi, res_lo} = sprod;
            MD_MULTU: {res_hi, res_lo} = uprod;
            MD_MADD:  {res_hi, res_lo} = acc + sprod;
            MD_MADDU: {res_hi, res_lo} = acc + uprod;
            MD_DIV: begin
                if (s_ovf) begin
                    res_hi = '0;
                    res_lo = SMIN;
                end else if (!b_zero) begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            MD_DIVU: begin
                if (!b_zero) begin
                    res_hi = a % b;
                    res_lo = a / b;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO for the E stage.
// Ports: clk, reset, E_MDOp, E_Start, E_A, E_B in; E_Busy, E_HI, E_LO out.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       E_MDOp,
    input  logic             E_Start,
    input  logic [WIDTH-1:0] E_A,
    input  logic [WIDTH-1:0] E_B,
    output logic             E_Busy,
    output logic [WIDTH-1:0] E_HI,
    output logic [WIDTH-1:0] E_LO
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] hi, hi_n;
    logic [WIDTH-1:0] lo, lo_n;
    logic [WIDTH-1:0] pend_hi, pend_hi_n;
    logic [WIDTH-1:0] pend_lo, pend_lo_n;
    logic [WIDTH-1:0] res_hi, res_lo;

    logic do_launch;
    logic do_mthi;
    logic do_mtlo;

    assign do_launch = E_Start && is_launch(E_MDOp);
    assign do_mthi = (E_MDOp == MD_MTHI);
    assign do_mtlo = (E_MDOp == MD_MTLO);

    md_unit_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (E_MDOp),
        .a      (E_A),
        .b      (E_B),
        .hi     (hi),
        .lo     (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            hi      <= hi_n;
            lo      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        hi_n      = hi;
        lo_n      = lo;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    do_launch: begin
                        pend_hi_n = res_hi;
                        pend_lo_n = res_lo;
                        cnt_n     = is_div(E_MDOp) ? DIV_N : MULT_N;
                        state_n   = RUN;
                    end
                    do_mthi: hi_n = E_A;
                    do_mtlo: lo_n = E_A;
                    default: ;
                endcase
            end
            RUN: begin
                // last busy cycle commits the pending result
                if (cnt == ONE) begin
                    hi_n    = pend_hi;
                    lo_n    = pend_lo;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign E_Busy = (state == RUN);
    assign E_HI   = hi;
    assign E_LO   = lo;

endmodule

// File: tb/tb_md_unit.sv
// Randomised self-checking bench for md_unit.
// Reference model: 64-bit arithmetic on HI/LO, timing from op latency.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_MDOp = 4'd0;
    logic        E_Start = 1'b0;
    logic [31:0] E_A = '0;
    logic [31:0] E_B = '0;
    logic        E_Busy;
    logic [31:0] E_HI, E_LO;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    md_unit #(
        .WIDTH(32), .MULT_CYCLES(MULT_N),
        .DIV_CYCLES(DIV_N), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .E_MDOp(E_MDOp),
        .E_Start(E_Start), .E_A(E_A), .E_B(E_B),
        .E_Busy(E_Busy), .E_HI(E_HI), .E_LO(E_LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [63:0] md_ref(
        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
        input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, acc, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {hi, lo};
        res = acc;
        case (op)
            4'd1: res = sa * sb;
            4'd2: res = ua * ub;
            4'd5: res = acc + 64'(sa * sb);
            4'd6: res = acc + ua * ub;
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd4: if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            default: ;
        endcase
        return res;
    endfunction

    task automatic launch(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int n;
        n = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
        exp = md_ref(op, a, b, mhi, mlo);
        @(posedge clk); #1;
        E_MDOp = op; E_A = a; E_B = b; E_Start = 1'b1;
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDOp = 4'd0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_run", 64'(E_Busy), 64'd1);
            chk("hold_hilo", {E_HI, E_LO}, {mhi, mlo});
        end
        @(negedge clk);
        chk("busy_done", 64'(E_Busy), 64'd0);
        chk("hilo", {E_HI, E_LO}, exp);
        {mhi, mlo} = exp;
    endtask

    task automatic mt(input logic hi_sel, input logic [31:0] v);
        @(posedge clk); #1;
        E_MDOp = hi_sel ? 4'd7 : 4'd8; E_A = v;
        @(posedge clk); #1;
        E_MDOp = 4'd0;
        if (hi_sel) mhi = v; else mlo = v;
        @(negedge clk);
        chk("mt_hilo", {E_HI, E_LO}, {mhi, mlo});
        chk("mt_busy", 64'(E_Busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(E_Busy), 64'd0);
        chk("rst_hilo", {E_HI, E_LO}, 64'd0);

        launch(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_lit", {E_HI, E_LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        launch(4'd2, 32'hFFFF_FFFF, 32'd2);
        chk("multu_lit", {E_HI, E_LO}, 64'h0000_0001_FFFF_FFFE);
        launch(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lit", {E_HI, E_LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        mt(1'b1, 32'h1234);
        mt(1'b0, 32'h5678);
        launch(4'd4, 32'd5, 32'd0);
        chk("divz_lit", {E_HI, E_LO}, 64'h0000_1234_0000_5678);
        launch(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("dovf_lit", {E_HI, E_LO}, 64'h0000_0000_8000_0000);

        mt(1'b0, 32'hFFFF_FFFF);
        mt(1'b1, 32'h0);
        launch(4'd5, 32'd1, 32'd1);
        chk("madd_lit", {E_HI, E_LO}, 64'h0000_0001_0000_0000);
        launch(4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("maddu_lit", {E_HI, E_LO}, 64'hFFFF_FFFF_0000_0001);

        // start and mtlo while busy must be ignored
        @(posedge clk); #1;
        E_MDOp = 4'd1; E_A = 32'd3; E_B = 32'd4; E_Start = 1'b1;
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDOp = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) begin
                E_MDOp = 4'd3; E_A = 32'd9; E_B = 32'd3; E_Start = 1'b1;
            end else if (k == 3) begin
                E_MDOp = 4'd8; E_A = 32'hAA; E_Start = 1'b0;
            end else begin
                E_MDOp = 4'd0; E_Start = 1'b0;
            end
            @(negedge clk);
            chk("swb_busy", 64'(E_Busy), (k <= 5) ? 64'd1 : 64'd0);
            if (k < 6) begin
                @(posedge clk); #1;
            end
        end
        chk("swb_hilo", {E_HI, E_LO}, 64'd12);
        mhi = 32'd0; mlo = 32'd12;

        // reset in the middle of a divide
        mt(1'b1, 32'h55);
        @(posedge clk); #1;
        E_MDOp = 4'd3; E_A = 32'd100; E_B = 32'd7; E_Start = 1'b1;
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDOp = 4'd0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rmid_busy", 64'(E_Busy), 64'd0);
        chk("rmid_hilo", {E_HI, E_LO}, 64'd0);
        mhi = '0; mlo = '0;
        launch(4'd1, 32'd2, 32'd3);
        chk("rmid_mult", 64'(E_LO), 64'd6);

        // start with a non-launch op is ignored
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            E_MDOp = (k == 0) ? 4'd0 : 4'd9;
            E_A = 32'hDEAD; E_Start = 1'b1;
            @(posedge clk); #1;
            E_Start = 1'b0; E_MDOp = 4'd0;
            @(negedge clk);
            chk("bad_busy", 64'(E_Busy), 64'd0);
            chk("bad_hilo", {E_HI, E_LO}, {mhi, mlo});
        end

        for (int it = 0; it < 60; it++) begin
            op = 4'($urandom_range(1, 8));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if (op == 4'd7) mt(1'b1, a);
            else if (op == 4'd8) mt(1'b0, a);
            else launch(op, a, b);
        end

        exp = {mhi, mlo};
        chk("final_hilo", {E_HI, E_LO}, exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the E stage of the 5-stage pipeline, with HI/LO registers.
- Executes mult/multu/div/divu/madd/maddu/mthi/mtlo.
- The latency of each operation class is set by a parameter, and the unit exposes busy so the hazard controller can stall D-stage md-class instructions.
- HI/LO values feed the E-stage result mux for mfhi/mflo.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous active-high reset
E_MDOp  in  4  operation code, valid while E_Start=1 or for mthi/mtlo
E_Start  in  1  launch mult/multu/div/divu/madd/maddu this cycle
E_A  in  WIDTH  forwarded rs value
E_B  in  WIDTH  forwarded rt value
E_Busy  out  1  1 while an operation is in flight
E_HI  out  WIDTH  architectural HI register
E_LO  out  WIDTH  architectural LO register

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: HI=0, LO=0, E_Busy=0, counter=0, pending HI/LO=0.
- Reset mid-operation aborts the operation: the pending result is discarded, E_Busy=0 and HI/LO=0 on the next cycle.
- States:
  - IDLE (E_Busy=0).
  - RUN (E_Busy=1, counter counting down).
- IDLE with E_Start=1 and a launch op at cycle t:
  - At posedge t, operands are computed into pending_hi/pending_lo and the counter is loaded with the op latency N.
  - E_Busy=1 during cycles t+1 .. t+N.
  - At the posedge ending cycle t+N, HI/LO take the pending values and the unit returns to IDLE.
  - New HI/LO are visible from cycle t+N+1, where E_Busy=0.
- Operation results:
  - mult: {HI,LO} = signed A*B (2*WIDTH bits).
  - multu: {HI,LO} = unsigned A*B.
  - madd: {HI,LO} = {HI,LO} + signed A*B.
  - maddu: {HI,LO} = {HI,LO} + unsigned A*B.
  - madd/maddu use HI/LO sampled at launch; the sum wraps at 2*WIDTH bits.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient in LO, remainder in HI.
  - Division by zero (B==0): the operation still occupies DIV_CYCLES, and HI/LO keep their prior values.
  - Signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0.
- mthi/mtlo:
  - Executed in IDLE with E_Start ignored for these ops; they are recognised by E_MDOp alone.
  - HI<=E_A (mthi) or LO<=E_A (mtlo) at the next posedge, no busy.
  - Ignored if E_Busy=1; the hazard controller never issues them then.
- E_Start=1 while E_Busy=1 is ignored; the current operation continues unaffected.
- E_Start=1 with a non-launch op, or MD_NONE, is ignored.
- E_HI/E_LO are register outputs; they never change while E_Busy=1.
- The hazard controller stalls D if the D instruction is md-class and (E_Start | E_Busy); this unit does not drive stall itself.

Decomposition:
- Shared constants header (alongside the existing ALU/forwarding constants):
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MADD=5, MD_MADDU=6, MD_MTHI=7, MD_MTLO=8.
  - RS_HI and RS_LO register-write-source codes for mfhi/mflo.
- The Controller decodes E_MDOp, E_Start and md-class flags.
- No sub-module is required; the arithmetic is behavioural in md_unit.
- An optional md_arith combinational sub-module computes pending_hi/pending_lo from op, A, B, HI and LO.

Test Plan:
- Reset then mult: A=0xFFFFFFFE (-2), B=3, E_Start at t -> E_Busy=1 for t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA, E_Busy=0.
- multu and div:
  - multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
  - div A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
- Divide by zero and overflow:
  - mthi 0x1234, mtlo 0x5678, then divu A=5, B=0 -> 10 busy cycles, then HI=0x1234, LO=0x5678.
  - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- madd accumulate: mtlo 0xFFFFFFFF, mthi 0, madd A=1, B=1 -> HI=1, LO=0; then maddu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFF, LO=1 (wrap).
- Start-while-busy and mt ignored: launch mult 3*4, assert E_Start with div 9/3 and mtlo 0xAA at cycle t+2 -> final HI=0, LO=12; E_Busy drops exactly at t+6.
- Reset mid-op: launch div 100/7, assert reset at t+4 -> next cycle E_Busy=0, HI=LO=0; a new mult 2*3 after reset gives LO=6.
